// File: rtl/sequenciador_medida_pkg.sv
// Shared definitions for the DHT11 measurement scheduler: state encoding,
// reply frame layout and counter sizing.
package sequenciador_medida_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        PULSO    = 4'd2,
        RECEBE   = 4'd3,
        ATUALIZA = 4'd4,
        FALHA    = 4'd5
    } estado_t;

    localparam int BYTES_QUADRO = 4;

    localparam logic [1:0] IDX_TEMP_LO = 2'd0;
    localparam logic [1:0] IDX_TEMP_HI = 2'd1;
    localparam logic [1:0] IDX_UMID_LO = 2'd2;
    localparam logic [1:0] IDX_UMID_HI = 2'd3;

    // Width of a counter holding 0..m-1, never narrower than one bit.
    function automatic int largura_contador(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M counter with synchronous clear, count enable and a flag
// that is high while the count sits at its last value (M-1).
module contador_m
    import sequenciador_medida_pkg::*;
#(
    parameter int M = 10,
    parameter int W = largura_contador(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic fim
);

    logic [W-1:0] valor_r;

    // Count register; clear has priority over enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_r <= '0;
        end else if (limpa) begin
            valor_r <= '0;
        end else if (conta) begin
            if (valor_r == W'(M - 1)) begin
                valor_r <= '0;
            end else begin
                valor_r <= valor_r + W'(1);
            end
        end else begin
            valor_r <= valor_r;
        end
    end

    assign fim = (valor_r == W'(M - 1));

endmodule

// File: rtl/sequenciador_medida.sv
// Periodic DHT11 measurement scheduler: triggers the sensor, gathers the
// 4-byte UART reply, retries on error/timeout and publishes results atomically.
module sequenciador_medida
    import sequenciador_medida_pkg::*;
#(
    parameter int PERIODO_AMOSTRA = 100_000_000,
    parameter int TIMEOUT         = 500_000,
    parameter int LARGURA_PULSO   = 50,
    parameter int MAX_TENTATIVAS  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic        medir_agora,
    input  logic [7:0]  rx_dado,
    input  logic        rx_pronto,
    input  logic        rx_erro_paridade,
    output logic        medir_dht11,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        medida_valida,
    output logic        erro_medida,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    localparam int WT = largura_contador(MAX_TENTATIVAS + 1);

    estado_t        estado_r;
    estado_t        estado_prox_s;
    logic           fim_periodo_s;
    logic           fim_pulso_s;
    logic           fim_timeout_s;
    logic           aceita_s;
    logic           ultimo_s;
    logic           aborta_s;
    logic           esgotou_s;
    logic [1:0]     indice_r;
    logic [WT-1:0]  tentativa_r;
    logic [15:0]    sombra_temp_r;
    logic [7:0]     sombra_umid_lo_r;
    logic           medir_dht11_r;
    logic [15:0]    temperatura_r;
    logic [15:0]    umidade_r;
    logic           medida_valida_r;
    logic           erro_medida_r;
    logic           ocupado_r;

    contador_m #(.M(PERIODO_AMOSTRA)) u_periodo (
        .clock (clock),
        .reset (reset),
        .limpa (estado_r != ESPERA),
        .conta (estado_r == ESPERA),
        .fim   (fim_periodo_s)
    );

    contador_m #(.M(LARGURA_PULSO)) u_pulso (
        .clock (clock),
        .reset (reset),
        .limpa (estado_r != PULSO),
        .conta (estado_r == PULSO),
        .fim   (fim_pulso_s)
    );

    contador_m #(.M(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .limpa (estado_r != RECEBE),
        .conta (estado_r == RECEBE),
        .fim   (fim_timeout_s)
    );

    // Byte acceptance, abort detection and next-state selection.
    always_comb begin
        estado_prox_s = estado_r;
        aceita_s      = (estado_r == RECEBE) && rx_pronto && !rx_erro_paridade;
        ultimo_s      = aceita_s && (indice_r == IDX_UMID_HI);
        // A completed frame beats a timeout landing on the same cycle.
        aborta_s      = (estado_r == RECEBE) && !ultimo_s &&
                        ((rx_pronto && rx_erro_paridade) || fim_timeout_s);
        esgotou_s     = (32'(tentativa_r) + 32'd1) >= 32'(MAX_TENTATIVAS);
        if (!habilita) begin
            estado_prox_s = INICIAL;
        end else begin
            case (estado_r)
                INICIAL:  estado_prox_s = PULSO;
                ESPERA: begin
                    if (medir_agora || fim_periodo_s) begin
                        estado_prox_s = PULSO;
                    end else begin
                        estado_prox_s = ESPERA;
                    end
                end
                PULSO: begin
                    if (fim_pulso_s) begin
                        estado_prox_s = RECEBE;
                    end else begin
                        estado_prox_s = PULSO;
                    end
                end
                RECEBE: begin
                    if (ultimo_s) begin
                        estado_prox_s = ATUALIZA;
                    end else if (aborta_s) begin
                        estado_prox_s = esgotou_s ? FALHA : PULSO;
                    end else begin
                        estado_prox_s = RECEBE;
                    end
                end
                ATUALIZA: estado_prox_s = ESPERA;
                FALHA:    estado_prox_s = ESPERA;
                default:  estado_prox_s = INICIAL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Byte index within the frame and attempt counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            indice_r    <= 2'd0;
            tentativa_r <= '0;
        end else begin
            if (estado_r != RECEBE) begin
                indice_r <= 2'd0;
            end else if (aceita_s) begin
                indice_r <= indice_r + 2'd1;
            end else begin
                indice_r <= indice_r;
            end
            if (!habilita || (estado_r == ATUALIZA) || (estado_r == FALHA)) begin
                tentativa_r <= '0;
            end else if (aborta_s && !esgotou_s) begin
                tentativa_r <= tentativa_r + WT'(1);
            end else begin
                tentativa_r <= tentativa_r;
            end
        end
    end

    // Shadow bytes; the last byte goes straight to the published word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sombra_temp_r    <= 16'h0000;
            sombra_umid_lo_r <= 8'h00;
        end else if (aceita_s) begin
            case (indice_r)
                IDX_TEMP_LO: sombra_temp_r[7:0]  <= rx_dado;
                IDX_TEMP_HI: sombra_temp_r[15:8] <= rx_dado;
                IDX_UMID_LO: sombra_umid_lo_r    <= rx_dado;
                default:     sombra_umid_lo_r    <= sombra_umid_lo_r;
            endcase
        end else begin
            sombra_temp_r    <= sombra_temp_r;
            sombra_umid_lo_r <= sombra_umid_lo_r;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            medir_dht11_r   <= 1'b0;
            ocupado_r       <= 1'b0;
            medida_valida_r <= 1'b0;
            temperatura_r   <= 16'h0000;
            umidade_r       <= 16'h0000;
            erro_medida_r   <= 1'b0;
        end else begin
            medir_dht11_r   <= (estado_prox_s == PULSO);
            ocupado_r       <= (estado_prox_s == PULSO) || (estado_prox_s == RECEBE) ||
                               (estado_prox_s == ATUALIZA);
            medida_valida_r <= (estado_prox_s == ATUALIZA);
            if (estado_prox_s == ATUALIZA) begin
                temperatura_r <= sombra_temp_r;
                umidade_r     <= {rx_dado, sombra_umid_lo_r};
                erro_medida_r <= 1'b0;
            end else if (estado_prox_s == FALHA) begin
                temperatura_r <= temperatura_r;
                umidade_r     <= umidade_r;
                erro_medida_r <= 1'b1;
            end else begin
                temperatura_r <= temperatura_r;
                umidade_r     <= umidade_r;
                erro_medida_r <= erro_medida_r;
            end
        end
    end

    assign medir_dht11   = medir_dht11_r;
    assign temperatura   = temperatura_r;
    assign umidade       = umidade_r;
    assign medida_valida = medida_valida_r;
    assign erro_medida   = erro_medida_r;
    assign ocupado       = ocupado_r;
    assign db_estado     = estado_r;

endmodule

// File: tb/tb_sequenciador_medida.sv
// Self-checking bench for sequenciador_medida: a duration/queue based model
// is compared every cycle, plus literal checks on the key scenarios.
module tb_sequenciador_medida;

    localparam int PER  = 1000;
    localparam int TMO  = 300;
    localparam int LARG = 5;
    localparam int MAXT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        habilita = 1'b0;
    logic        medir_agora = 1'b0;
    logic [7:0]  rx_dado = 8'h00;
    logic        rx_pronto = 1'b0;
    logic        rx_erro_paridade = 1'b0;
    logic        medir_dht11;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        medida_valida;
    logic        erro_medida;
    logic        ocupado;
    logic [3:0]  db_estado;

    sequenciador_medida #(
        .PERIODO_AMOSTRA (PER),
        .TIMEOUT         (TMO),
        .LARGURA_PULSO   (LARG),
        .MAX_TENTATIVAS  (MAXT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .habilita         (habilita),
        .medir_agora      (medir_agora),
        .rx_dado          (rx_dado),
        .rx_pronto        (rx_pronto),
        .rx_erro_paridade (rx_erro_paridade),
        .medir_dht11      (medir_dht11),
        .temperatura      (temperatura),
        .umidade          (umidade),
        .medida_valida    (medida_valida),
        .erro_medida      (erro_medida),
        .ocupado          (ocupado),
        .db_estado        (db_estado)
    );

    always #5 clock = ~clock;

    int testes = 0;
    int falhas = 0;
    int ciclo  = 0;

    // Model: phase numbers, time spent in phase, and a byte queue.
    int          m_fase = 0;
    int          m_t_ent = 0;
    int          m_tent = 0;
    logic [7:0]  m_bytes[$];
    logic        exp_pulso = 1'b0;
    logic        exp_valida = 1'b0;
    logic        exp_erro = 1'b0;
    logic        exp_ocupado = 1'b0;
    logic [15:0] exp_temp = 16'h0000;
    logic [15:0] exp_umid = 16'h0000;
    logic [3:0]  exp_estado = 4'd0;

    int pulsos[$];
    int largura_atual = 0;
    int ultima_largura = 0;
    logic pulso_ant = 1'b0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
        end
    endtask

    task automatic modelo_passo();
        int n;
        int prox;
        ciclo++;
        if (reset) begin
            m_fase = 0; m_tent = 0; m_bytes.delete();
            exp_pulso = 1'b0; exp_valida = 1'b0; exp_erro = 1'b0; exp_ocupado = 1'b0;
            exp_temp = 16'h0000; exp_umid = 16'h0000; exp_estado = 4'd0;
        end else begin
            n = ciclo - m_t_ent;
            prox = m_fase;
            exp_valida = 1'b0;
            if (!habilita) begin
                prox = 0;
                m_bytes.delete();
            end else begin
                case (m_fase)
                    0: begin prox = 2; m_tent = 1; end
                    1: if (medir_agora || n == PER) begin prox = 2; m_tent = 1; end
                    2: if (n == LARG) begin prox = 3; m_bytes.delete(); end
                    3: begin
                        if (rx_pronto && !rx_erro_paridade) m_bytes.push_back(rx_dado);
                        if (m_bytes.size() == 4) begin
                            prox = 4; exp_valida = 1'b1; exp_erro = 1'b0;
                            exp_temp = {m_bytes[1], m_bytes[0]};
                            exp_umid = {m_bytes[3], m_bytes[2]};
                        end else if ((rx_pronto && rx_erro_paridade) || n == TMO) begin
                            if (m_tent < MAXT) begin prox = 2; m_tent++; end
                            else begin prox = 5; exp_erro = 1'b1; end
                        end
                    end
                    4, 5: prox = 1;
                    default: prox = 0;
                endcase
            end
            if (prox != m_fase) m_t_ent = ciclo;
            m_fase = prox;
            exp_pulso = (prox == 2);
            exp_ocupado = (prox == 2) || (prox == 3) || (prox == 4);
            exp_estado = 4'(prox);
        end
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        modelo_passo();
    end

    // Every-cycle comparison against the model, plus pulse timing monitor.
    initial forever begin
        @(negedge clock);
        chk("medir_dht11", 32'(medir_dht11), 32'(exp_pulso));
        chk("temperatura", 32'(temperatura), 32'(exp_temp));
        chk("umidade", 32'(umidade), 32'(exp_umid));
        chk("medida_valida", 32'(medida_valida), 32'(exp_valida));
        chk("erro_medida", 32'(erro_medida), 32'(exp_erro));
        chk("ocupado", 32'(ocupado), 32'(exp_ocupado));
        chk("db_estado", 32'(db_estado), 32'(exp_estado));
        if (medir_dht11 && !pulso_ant) pulsos.push_back(ciclo);
        if (medir_dht11) largura_atual++;
        else if (pulso_ant) begin ultima_largura = largura_atual; largura_atual = 0; end
        pulso_ant = medir_dht11;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic esperar_estado(input logic [3:0] alvo, input int limite, input string nome);
        int k = 0;
        while (db_estado != alvo && k < limite) begin @(negedge clock); k++; end
        chk(nome, 32'(db_estado), 32'(alvo));
    endtask

    task automatic pedir();
        medir_agora = 1'b1;
        @(negedge clock);
        medir_agora = 1'b0;
    endtask

    task automatic enviar(input logic [7:0] b, input logic err, input int gap);
        repeat (gap) @(negedge clock);
        rx_dado = b; rx_erro_paridade = err; rx_pronto = 1'b1;
        @(negedge clock);
        rx_pronto = 1'b0; rx_erro_paridade = 1'b0;
    endtask

    task automatic enviar_quadro(output logic [15:0] t, output logic [15:0] u);
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            enviar(b[i], 1'b0, $urandom_range(0, 3));
        end
        t = {b[1], b[0]};
        u = {b[3], b[2]};
    endtask

    initial begin
        logic [15:0] t, u, t2, u2;
        int r, e, k, p, modo, nb;

        tick(3);
        chk("reset_temp", 32'(temperatura), 32'h0);
        chk("reset_estado", 32'(db_estado), 32'h0);
        chk("reset_pulso", 32'(medir_dht11), 32'h0);
        #2 reset = 1'b0;

        // 1: first measurement is immediate
        habilita = 1'b1;
        esperar_estado(4'd3, 50, "s1_recebe");
        enviar(8'h02, 1'b0, 1); enviar(8'h22, 1'b0, 0);
        enviar(8'h34, 1'b0, 2); enviar(8'h12, 1'b0, 1);
        chk("s1_valida_lat", 32'(medida_valida), 32'h1);
        chk("s1_temp", 32'(temperatura), 32'h2202);
        chk("s1_umid", 32'(umidade), 32'h1234);
        chk("s1_erro", 32'(erro_medida), 32'h0);
        chk("s1_largura", 32'(ultima_largura), 32'd5);
        chk("s1_npulsos", 32'(pulsos.size()), 32'd1);
        tick(1);
        chk("s1_valida_1ciclo", 32'(medida_valida), 32'h0);

        // 2: parity error then retry
        esperar_estado(4'd1, 10, "s2_espera");
        pedir();
        esperar_estado(4'd3, 20, "s2_recebe");
        enviar(8'h05, 1'b0, 0); enviar(8'h00, 1'b1, 1);
        chk("s2_repulso", 32'(medir_dht11), 32'h1);
        esperar_estado(4'd3, 20, "s2_recebe2");
        enviar(8'h05, 1'b0, 0); enviar(8'h00, 1'b0, 0);
        enviar(8'h40, 1'b0, 0); enviar(8'h00, 1'b0, 0);
        chk("s2_temp", 32'(temperatura), 32'h0005);
        chk("s2_umid", 32'(umidade), 32'h0040);

        // 3: silence on every attempt -> failure
        esperar_estado(4'd1, 10, "s3_espera");
        pedir();
        k = 0;
        while (!erro_medida && k < 1200) begin @(negedge clock); k++; end
        chk("s3_erro", 32'(erro_medida), 32'h1);
        p = pulsos.size();
        chk("s3_gap1", 32'(pulsos[p-1] - pulsos[p-2]), 32'd305);
        chk("s3_gap2", 32'(pulsos[p-2] - pulsos[p-3]), 32'd305);
        chk("s3_temp_retida", 32'(temperatura), 32'h0005);
        esperar_estado(4'd1, 10, "s3_espera2");
        pedir();
        esperar_estado(4'd3, 20, "s3_recebe");
        enviar_quadro(t, u);
        chk("s3_erro_limpo", 32'(erro_medida), 32'h0);
        chk("s3_temp_nova", 32'(temperatura), 32'(t));

        // 4: medir_agora timing and periodic restart
        esperar_estado(4'd1, 10, "s4_espera");
        tick(100);
        pedir();
        chk("s4_pulso_imediato", 32'(medir_dht11), 32'h1);
        esperar_estado(4'd3, 20, "s4_recebe");
        pedir();
        enviar_quadro(t, u);
        esperar_estado(4'd1, 10, "s4_espera2");
        e = ciclo;
        k = 0;
        while (!medir_dht11 && k < 1100) begin @(negedge clock); k++; end
        chk("s4_periodo", 32'(ciclo - e), 32'd1000);

        // 5: reset and habilita=0 mid-frame
        esperar_estado(4'd3, 20, "s5_recebe");
        enviar(8'h11, 1'b0, 0); enviar(8'h22, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        chk("s5_rst_temp", 32'(temperatura), 32'h0);
        chk("s5_rst_umid", 32'(umidade), 32'h0);
        chk("s5_rst_estado", 32'(db_estado), 32'h0);
        chk("s5_rst_ocupado", 32'(ocupado), 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;
        esperar_estado(4'd3, 20, "s5_recebe2");
        enviar_quadro(t, u);
        esperar_estado(4'd1, 10, "s5_espera");
        pedir();
        esperar_estado(4'd3, 20, "s5_recebe3");
        enviar(8'h33, 1'b0, 0); enviar(8'h44, 1'b0, 0);
        habilita = 1'b0;
        tick(2);
        chk("s5_inicial", 32'(db_estado), 32'h0);
        chk("s5_temp_retida", 32'(temperatura), 32'(t));
        chk("s5_umid_retida", 32'(umidade), 32'(u));
        habilita = 1'b1;
        esperar_estado(4'd3, 20, "s5_recebe4");
        enviar_quadro(t2, u2);
        chk("s5_temp_fresca", 32'(temperatura), 32'(t2));
        chk("s5_umid_fresca", 32'(umidade), 32'(u2));

        // 6: stray byte in ESPERA; 4th byte on the timeout cycle
        esperar_estado(4'd1, 10, "s6_espera");
        enviar(8'hAA, 1'b0, 0);
        chk("s6_ignorado", 32'(db_estado), 32'h1);
        pedir();
        esperar_estado(4'd3, 20, "s6_recebe");
        r = ciclo;
        enviar(8'h01, 1'b0, 0); enviar(8'h02, 1'b0, 0); enviar(8'h03, 1'b0, 0);
        while (ciclo < r + TMO - 1) @(negedge clock);
        enviar(8'h04, 1'b0, 0);
        chk("s6_limite_valida", 32'(medida_valida), 32'h1);
        chk("s6_limite_umid", 32'(umidade), 32'h0403);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            k = 0;
            while (db_estado != 4'd1 && db_estado != 4'd3 && k < 400) begin
                @(negedge clock); k++;
            end
            if (db_estado == 4'd1) begin
                if ($urandom_range(0, 3) == 0) enviar(8'($urandom), 1'($urandom), 0);
                pedir();
            end else if (db_estado == 4'd3) begin
                modo = $urandom_range(0, 9);
                if (modo == 0) begin
                    k = 0;
                    while (db_estado == 4'd3 && k < 400) begin @(negedge clock); k++; end
                end else if (modo == 1) begin
                    nb = $urandom_range(0, 3);
                    repeat (nb) enviar(8'($urandom), 1'b0, $urandom_range(0, 3));
                    enviar(8'($urandom), 1'b1, $urandom_range(0, 3));
                end else begin
                    enviar_quadro(t, u);
                end
            end else begin
                chk("rand_estado_preso", 32'(db_estado), 32'h1);
            end
        end
        tick(3);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
